// File: rtl/multu_ctl.sv
// multu_ctl: iterative shift-add unsigned multiplier with HI/LO registers,
// mfhi/mflo read mux and a pipeline stall request while the multiply runs.
module multu_ctl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       rd_sel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q;
    logic [2*WIDTH-1:0] mcand_q, product_q, product_d;
    logic [WIDTH-1:0]   mplier_q, hi_q, lo_q;
    logic [CW-1:0]      count_q;
    logic               last;
    assign product_d = product_q + (mplier_q[0] ? mcand_q : '0);
    assign last      = count_q == CW'(WIDTH - 1);
    // the final step's sum goes straight into HI/LO so done and the result coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            product_q <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (state_q == RUN) begin
            product_q <= product_d;
            mcand_q   <= mcand_q << 1;
            mplier_q  <= mplier_q >> 1;
            count_q   <= count_q + CW'(1);
            if (last) begin
                state_q      <= DONE;
                {hi_q, lo_q} <= product_d;
            end
        end else if (start) begin
            state_q   <= RUN;
            mcand_q   <= {{WIDTH{1'b0}}, a};
            mplier_q  <= b;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q <= IDLE;
        end
    end
    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign stall    = busy & (rd_sel == 2'b01 | rd_sel == 2'b10 | start);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign hilo_out = rd_sel == 2'b01 ? hi_q : rd_sel == 2'b10 ? lo_q : '0;
endmodule

// File: tb/tb_multu_ctl.sv
// tb_multu_ctl: directed and random stimulus against a cycle-count model of
// the multiplier (result = a*b, visible WIDTH+1 cycles after acceptance).
module tb_multu_ctl;
    localparam int W = 32;
    logic           clk = 0, rst, start;
    logic [W-1:0]   a, b, hi, lo, hilo_out;
    logic [1:0]     rd_sel;
    logic           busy, done, stall;
    int             total = 0, bad = 0, cyc = 0, t0 = 0;
    bit             active = 0;
    logic [2*W-1:0] res = '0;
    logic [W-1:0]   m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    multu_ctl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .rd_sel(rd_sel),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .hilo_out(hilo_out)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit in_run();
        return active && cyc - t0 >= 1 && cyc - t0 <= W;
    endfunction

    // One clock period: drive inputs, check combinational outputs, advance the
    // model across the edge, then check the registered outputs.
    task automatic cycle(input bit s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [1:0] rd, input bit r);
        bit run;
        start = s; a = av; b = bv; rd_sel = rd; rst = r;
        #1;
        run = in_run();
        chk("stall", stall, W'(run && (rd == 2'b01 || rd == 2'b10 || s)));
        chk("hilo_out", hilo_out, rd == 2'b01 ? m_hi : rd == 2'b10 ? m_lo : '0);
        if (r) begin
            active = 0; m_hi = '0; m_lo = '0;
        end else begin
            if (run && cyc - t0 == W) {m_hi, m_lo} = res;
            if (s && !run) begin
                active = 1; t0 = cyc;
                res = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
            end
        end
        @(posedge clk); #1; cyc++;
        chk("busy", busy, W'(in_run()));
        chk("done", done, W'(active && cyc - t0 == W + 1));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic idle(input int n, input logic [1:0] rd);
        repeat (n) cycle(0, '0, '0, rd, 0);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        cycle(1, av, bv, 2'b00, 0);
        idle(W, 2'b00);
        chk("op_done", done, 1);
    endtask

    initial begin
        rst = 1; start = 0; a = '0; b = '0; rd_sel = '0;
        @(posedge clk); #1;
        cycle(0, '0, '0, 2'b00, 1);
        chk("rst_hi", hi, 0);
        chk("rst_busy", busy, 0);

        run_op(3, 5);
        chk("lo_3x5", lo, 15);
        chk("hi_3x5", hi, 0);
        idle(1, 2'b00);

        run_op('1, '1);
        chk("hi_max", hi, 32'hFFFF_FFFE);
        chk("lo_max", lo, 32'h0000_0001);
        run_op(32'h8000_0000, 2);
        chk("hi_msb", hi, 1);
        chk("lo_msb", lo, 0);
        run_op(0, 32'h1234_5678);
        chk("hi_zero", hi, 0);
        idle(2, 2'b00);

        // mfhi held from cycle 5, then mfhi/mflo in the done cycle
        cycle(1, 7, 9, 2'b00, 0);
        idle(4, 2'b00);
        idle(28, 2'b01);
        rd_sel = 2'b01; #1;
        chk("stall_done", stall, 0);
        chk("mfhi_done", hilo_out, 0);
        rd_sel = 2'b10; #1;
        chk("mflo_done", hilo_out, 63);
        cycle(0, '0, '0, 2'b10, 0);
        idle(1, 2'b00);

        // start during RUN is ignored; start in DONE issues back-to-back
        cycle(1, 2, 2, 2'b00, 0);
        idle(9, 2'b00);
        start = 1; a = 9; b = 9; #1;
        chk("stall_start", stall, 1);
        cycle(1, 9, 9, 2'b00, 0);
        idle(22, 2'b00);
        chk("first_lo", lo, 4);
        chk("first_done", done, 1);
        cycle(1, 4, 4, 2'b00, 0);
        idle(31, 2'b00);
        chk("lo_kept", lo, 4);
        idle(1, 2'b00);
        chk("second_done", done, 1);
        chk("second_lo", lo, 16);
        idle(1, 2'b00);

        // non-zero HI/LO beforehand so the abort's clear is visible
        run_op(32'hDEAD_BEEF, 32'h1234_5678);
        idle(1, 2'b00);
        cycle(1, 5, 6, 2'b00, 0);
        idle(9, 2'b00);
        cycle(0, '0, '0, 2'b00, 1);
        chk("abort_busy", busy, 0);
        chk("abort_lo", lo, 0);
        idle(40, 2'b00);

        repeat (1500) begin
            cycle($urandom_range(0, 3) == 0, $urandom, $urandom,
                  2'($urandom_range(0, 3)), $urandom_range(0, 200) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
